// File: rtl/dkong_video_pkg.sv
// Shared pixel format and line geometry for the Donkey Kong video path.
package dkong_video_pkg;

  localparam int unsigned H_ACTIVE = 256;
  localparam int unsigned H_TOTAL  = 384;

  typedef struct packed {
    logic [1:0] b;
    logic [2:0] g;
    logic [2:0] r;
  } rgb332_t;

  // Line counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == '1) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/dkong_linebuf.sv
// Ping-pong line store: 2 banks x 256 pixels, one write port, one registered read port.
module dkong_linebuf (
  input  logic                     clk,
  input  logic                     we,
  input  logic [8:0]               waddr,
  input  dkong_video_pkg::rgb332_t wdata,
  input  logic [8:0]               raddr,
  output dkong_video_pkg::rgb332_t rdata
);
  import dkong_video_pkg::*;

  rgb332_t mem [0:511];

  // Synchronous write and registered read; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/dkong_scandoubler.sv
// Line doubler: stores each 15 kHz source line and replays the previous one
// twice at double pixel rate to build a 31 kHz raster.
module dkong_scandoubler #(
  parameter int unsigned IN_DIV   = 10,
  parameter int unsigned H_ACTIVE = dkong_video_pkg::H_ACTIVE,
  parameter int unsigned H_TOTAL  = dkong_video_pkg::H_TOTAL,
  parameter int unsigned HS_START = 272,
  parameter int unsigned HS_LEN   = 40,
  parameter int unsigned VS_START = 490,
  parameter int unsigned VS_LEN   = 2,
  parameter bit          SYNC_NEG = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_ce,
  input  logic       in_valid,
  input  logic [7:0] in_rgb,
  input  logic       in_line_start,
  input  logic       in_frame_start,
  output logic [2:0] vga_r,
  output logic [2:0] vga_g,
  output logic [1:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_de
);
  import dkong_video_pkg::*;

  localparam int unsigned      HALF_DIV = IN_DIV / 2;
  localparam int unsigned      DIV_W    = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);
  localparam logic [8:0]       ACT_END  = 9'(H_ACTIVE);
  localparam logic [8:0]       H_LAST   = 9'(H_TOTAL - 1);
  localparam logic [8:0]       HS_LO    = 9'(HS_START);
  localparam logic [8:0]       HS_HI    = 9'(HS_START + HS_LEN);
  localparam logic [9:0]       VS_LO    = 10'(VS_START);
  localparam logic [9:0]       VS_HI    = 10'(VS_START + VS_LEN);

  // Write side
  logic       wr_bank;
  logic [8:0] wr_addr;
  logic [1:0] bank_valid;
  logic       line_go;
  logic       next_bank;
  logic [8:0] wr_ptr;
  logic       we;
  logic [8:0] waddr;

  // Output timing
  logic [DIV_W-1:0] divider;
  logic             out_ce;
  logic [8:0]       hcount;
  logic [9:0]       vcount;

  // Read side and pipeline
  logic    rd_bank;
  logic [8:0] raddr;
  rgb332_t rdata;
  logic    de_s1;
  logic    hs_s1;
  logic    vs_s1;

  // Write decode: a line start redirects this very pixel to address 0 of the new bank.
  always_comb begin
    line_go   = pix_ce & (in_line_start | in_frame_start);
    next_bank = line_go ? ~wr_bank : wr_bank;
    wr_ptr    = line_go ? '0 : wr_addr;
    we        = pix_ce & in_valid & (wr_ptr < ACT_END);
    waddr     = {next_bank, wr_ptr[7:0]};
  end

  // Bank selection, saturating write pointer and per-bank "has data" flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank    <= 1'b0;
      wr_addr    <= '0;
      bank_valid <= '0;
    end else begin
      wr_bank <= next_bank;
      if (we) begin
        wr_addr               <= wr_ptr + 9'd1;
        bank_valid[next_bank] <= 1'b1;
      end else if (line_go) begin
        wr_addr               <= '0;
        bank_valid[next_bank] <= 1'b0;
      end
    end
  end

  // Output pixel strobe at twice the source rate.
  always_comb begin
    out_ce = (divider == DIV_LAST);
  end

  // Divider and output raster counters, re-phased to every source line start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divider <= '0;
      hcount  <= '0;
      vcount  <= '0;
    end else if (line_go) begin
      divider <= '0;
      hcount  <= '0;
      vcount  <= (pix_ce & in_frame_start) ? '0 : sat_inc10(vcount);
    end else if (out_ce) begin
      divider <= '0;
      if (hcount == H_LAST) begin
        hcount <= '0;
        vcount <= sat_inc10(vcount);
      end else begin
        hcount <= hcount + 9'd1;
      end
    end else begin
      divider <= divider + 1'b1;
    end
  end

  // Read the bank not being written.
  always_comb begin
    rd_bank = ~wr_bank;
    raddr   = {rd_bank, hcount[7:0]};
  end

  dkong_linebuf u_linebuf (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (rgb332_t'(in_rgb)),
    .raddr (raddr),
    .rdata (rdata)
  );

  // Stage 1: timing decode registered alongside the RAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_s1 <= 1'b0;
      hs_s1 <= 1'b0;
      vs_s1 <= 1'b0;
    end else begin
      de_s1 <= (hcount < ACT_END) & bank_valid[rd_bank];
      hs_s1 <= (hcount >= HS_LO) & (hcount < HS_HI);
      vs_s1 <= (vcount >= VS_LO) & (vcount < VS_HI);
    end
  end

  // Stage 2: output register with blanking and sync polarity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
      vga_de <= 1'b0;
      vga_hs <= SYNC_NEG;
      vga_vs <= SYNC_NEG;
    end else begin
      vga_r  <= de_s1 ? rdata.r : '0;
      vga_g  <= de_s1 ? rdata.g : '0;
      vga_b  <= de_s1 ? rdata.b : '0;
      vga_de <= de_s1;
      vga_hs <= hs_s1 ^ SYNC_NEG;
      vga_vs <= vs_s1 ^ SYNC_NEG;
    end
  end

endmodule

// File: tb/tb_dkong_scandoubler.sv
// Directed bench for dkong_scandoubler: reset, doubling, overlong line,
// early resync, sync placement/widths and an empty line.
module tb_dkong_scandoubler;

  localparam int LOG_N = 32768;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pix_ce;
  logic       in_valid;
  logic [7:0] in_rgb;
  logic       in_line_start;
  logic       in_frame_start;
  logic [2:0] vga_r;
  logic [2:0] vga_g;
  logic [1:0] vga_b;
  logic       vga_hs;
  logic       vga_vs;
  logic       vga_de;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // {vs, hs, de, b, g, r} per clock, indexed by posedge count
  logic [10:0] lg [0:LOG_N-1];

  dkong_scandoubler #(.VS_START(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pix_ce         (pix_ce),
    .in_valid       (in_valid),
    .in_rgb         (in_rgb),
    .in_line_start  (in_line_start),
    .in_frame_start (in_frame_start),
    .vga_r          (vga_r),
    .vga_g          (vga_g),
    .vga_b          (vga_b),
    .vga_hs         (vga_hs),
    .vga_vs         (vga_vs),
    .vga_de         (vga_de)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc < LOG_N) lg[cyc] = {vga_vs, vga_hs, vga_de, vga_b, vga_g, vga_r};
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rgb_at(input int i);
    logic [10:0] w;
    w = lg[i];
    return w[7:0];
  endfunction

  function automatic logic bit_at(input int i, input int pos);
    logic [10:0] w;
    w = lg[i];
    return w[pos];
  endfunction

  function automatic int cnt(input int lo, input int hi, input int pos, input logic v);
    int n;
    logic [10:0] w;
    n = 0;
    for (int i = lo; i <= hi; i++) begin
      w = lg[i];
      if (w[pos] === v) n++;
    end
    return n;
  endfunction

  function automatic logic [7:0] pix_val(input int kind, input int i);
    logic [7:0] v;
    v = 8'(i);
    case (kind)
      0:       return v;
      1:       return (i < 256) ? ~v : 8'h5A;
      2:       return v ^ 8'h33;
      default: return 8'h00;
    endcase
  endfunction

  // One source pixel slot: pix_ce for one clk, then nine idle clks.
  task automatic pix(input logic v, input logic [7:0] d, input logic ls, input logic fs);
    pix_ce = 1'b1; in_valid = v; in_rgb = d; in_line_start = ls; in_frame_start = fs;
    @(negedge clk);
    pix_ce = 1'b0; in_line_start = 1'b0; in_frame_start = 1'b0;
    repeat (9) @(negedge clk);
  endtask

  // base = log index of the clock just after the posedge that samples the line start
  task automatic src_line(input int nvalid, input int nslots, input int kind,
                          input logic fs, output int base);
    base = cyc + 1;
    for (int i = 0; i < nslots; i++)
      pix(i < nvalid, pix_val(kind, i), i == 0, fs && i == 0);
  endtask

  initial begin
    int b0, b1, b2, b3, b4;
    int xs;
    int k;
    rst_n = 1'b0;
    pix_ce = 1'b0; in_valid = 1'b0; in_rgb = '0; in_line_start = 1'b0; in_frame_start = 1'b0;

    // Reset held with random inputs
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("rst_de", 16'(vga_de), 16'd0);
      chk("rst_rgb", 16'({vga_b, vga_g, vga_r}), 16'd0);
      chk("rst_hs", 16'(vga_hs), 16'd1);
      chk("rst_vs", 16'(vga_vs), 16'd1);
      pix_ce = 1'($urandom); in_valid = 1'($urandom); in_rgb = 8'($urandom);
      in_line_start = 1'($urandom); in_frame_start = 1'($urandom);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pix_ce = 1'b0; in_valid = 1'b0; in_rgb = '0; in_line_start = 1'b0; in_frame_start = 1'b0;
    repeat (20) @(negedge clk);

    src_line(256, 384, 0, 1'b1, b0);  // rgb = x at x
    src_line(300, 384, 1, 1'b0, b1);  // overlong, ~x then 5A
    src_line(200, 200, 2, 1'b0, b2);  // cut short by next line start
    src_line(0, 384, 3, 1'b0, b3);    // empty
    src_line(0, 384, 3, 1'b0, b4);    // empty, lets line 3 be displayed
    repeat (10) @(negedge clk);

    // Output lines 0/1: nothing stored yet
    chk("l0_de", 16'(bit_at(b0 + 54, 8)), 16'd0);
    chk("l0_rgb", 16'(rgb_at(b0 + 54)), 16'd0);
    chk("l1_de", 16'(bit_at(b0 + 1974, 8)), 16'd0);
    chk("l0_vs", 16'(bit_at(b0 + 54, 10)), 16'd1);

    // Output lines 2/3: line 0 doubled
    for (int j = 0; j < 4; j++) begin
      k = (j == 0) ? 0 : (j == 1) ? 1 : (j == 2) ? 100 : 255;
      chk("dbl_a_rgb", 16'(rgb_at(b1 + 4 + 5*k)), 16'(k));
      chk("dbl_a_de", 16'(bit_at(b1 + 4 + 5*k, 8)), 16'd1);
      chk("dbl_b_rgb", 16'(rgb_at(b1 + 1924 + 5*k)), 16'(k));
    end
    chk("align_de_c1", 16'(bit_at(b1 + 1, 8)), 16'd0);
    chk("align_de_c2", 16'(bit_at(b1 + 2, 8)), 16'd1);
    chk("align_de_last", 16'(bit_at(b1 + 1281, 8)), 16'd1);
    chk("align_de_end", 16'(bit_at(b1 + 1282, 8)), 16'd0);
    chk("align_de_b0", 16'(bit_at(b1 + 1921, 8)), 16'd0);
    chk("align_de_b1", 16'(bit_at(b1 + 1922, 8)), 16'd1);
    chk("de_len_a", 16'(cnt(b1 + 2, b1 + 1921, 8, 1'b1)), 16'd1280);
    chk("de_len_b", 16'(cnt(b1 + 1922, b1 + 3841, 8, 1'b1)), 16'd1280);
    chk("hs_271", 16'(bit_at(b1 + 4 + 5*271, 9)), 16'd1);
    chk("hs_272", 16'(bit_at(b1 + 4 + 5*272, 9)), 16'd0);
    chk("hs_311", 16'(bit_at(b1 + 4 + 5*311, 9)), 16'd0);
    chk("hs_312", 16'(bit_at(b1 + 4 + 5*312, 9)), 16'd1);
    chk("hs_len_a", 16'(cnt(b1 + 2, b1 + 1921, 9, 1'b0)), 16'd200);
    chk("hs_len_b", 16'(cnt(b1 + 1922, b1 + 3841, 9, 1'b0)), 16'd200);
    chk("vs_l2", 16'(bit_at(b1 + 54, 10)), 16'd1);
    chk("vs_l3", 16'(bit_at(b1 + 1974, 10)), 16'd1);

    // Output lines 4/5: overlong line 1, only the first 256 stored
    chk("ovl_a0", 16'(rgb_at(b2 + 4)), 16'h00FF);
    chk("ovl_a44", 16'(rgb_at(b2 + 4 + 5*44)), 16'h00D3);
    chk("ovl_a255", 16'(rgb_at(b2 + 4 + 5*255)), 16'h0000);
    chk("ovl_a255_de", 16'(bit_at(b2 + 4 + 5*255, 8)), 16'd1);
    chk("ovl_de_len", 16'(cnt(b2 + 2, b2 + 1921, 8, 1'b1)), 16'd1280);
    chk("ovl_b0", 16'(rgb_at(b2 + 1924)), 16'h00FF);
    chk("vs_l4", 16'(bit_at(b2 + 54, 10)), 16'd0);
    chk("vs_l5", 16'(bit_at(b2 + 1929, 10)), 16'd0);

    // Early resync: line 5 cut at hcount 15, line 6 starts with line 2 data
    chk("rsync_pre_rgb", 16'(rgb_at(b3 + 1)), 16'h00F0);
    chk("rsync_pre_de", 16'(bit_at(b3 + 1, 8)), 16'd1);
    chk("rsync_post_rgb", 16'(rgb_at(b3 + 2)), 16'h0033);
    chk("rsync_post_de", 16'(bit_at(b3 + 2, 8)), 16'd1);
    chk("vs_l6", 16'(bit_at(b3 + 4, 10)), 16'd1);
    chk("l6_rgb199", 16'(rgb_at(b3 + 4 + 5*199)), 16'h00F4);
    chk("l7_rgb100", 16'(rgb_at(b3 + 1924 + 5*100)), 16'h0057);

    // Output lines 8/9: empty source line
    chk("empty_de_a", 16'(bit_at(b4 + 54, 8)), 16'd0);
    chk("empty_rgb_a", 16'(rgb_at(b4 + 54)), 16'd0);
    chk("empty_rgb_b", 16'(rgb_at(b4 + 1924 + 500)), 16'd0);
    chk("empty_de_cnt", 16'(cnt(b4 + 2, b4 + 3841, 8, 1'b1)), 16'd0);
    chk("empty_hs_a", 16'(cnt(b4 + 2, b4 + 1921, 9, 1'b0)), 16'd200);
    chk("empty_hs_b", 16'(cnt(b4 + 1922, b4 + 3841, 9, 1'b0)), 16'd200);

    // No unknowns on any output after reset
    xs = 0;
    for (int i = b0 - 20; i <= b4 + 3841; i++)
      if ($isunknown(lg[i])) xs++;
    chk("no_x", 16'(xs), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
